// File: rtl/dmem_handshake_slave.sv
// Word-addressed data memory behind a req/ready handshake with LATENCY wait states.
// Holds one request at a time; a combinational debug port reads any word directly.
module dmem_handshake_slave #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Req,
  input  logic                  We,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WData,
  output logic                  Ready,
  output logic [31:0]           RData,
  output logic                  Err,
  output logic                  Busy,
  input  logic [DEPTH_LOG2-1:0] DbgAddr,
  output logic [31:0]           DbgData
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [3:0]  Lat   = 4'(LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, mis_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mem_q [Depth];

  logic                  capture, enter_resp, commit;
  logic                  resp_we, resp_mis;
  logic [DEPTH_LOG2-1:0] resp_idx;

  logic unused_addr;
  assign unused_addr = ^Addr[31:DEPTH_LOG2+2];

  // With zero wait states the response is entered on the capture edge itself,
  // so the read must use the live inputs rather than the holding registers.
  always_comb begin
    if (state_q == StIdle) begin
      resp_we  = We;
      resp_mis = Addr[1:0] != 2'b00;
      resp_idx = Addr[DEPTH_LOG2+1:2];
    end else begin
      resp_we  = we_q;
      resp_mis = mis_q;
      resp_idx = idx_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Req) begin
          capture    = 1'b1;
          cnt_d      = Lat;
          enter_resp = (Lat == 4'd0);
          state_d    = (Lat == 4'd0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          enter_resp = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp) begin
      if (resp_mis) begin
        rdata_d = '0;
      end else if (!resp_we) begin
        rdata_d = mem_q[resp_idx];
      end
    end
  end

  assign commit = (state_q == StResp) && we_q && !mis_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (capture) begin
        we_q    <= We;
        mis_q   <= Addr[1:0] != 2'b00;
        idx_q   <= Addr[DEPTH_LOG2+1:2];
        wdata_q <= WData;
      end
      if (commit) begin
        mem_q[idx_q] <= wdata_q;
      end
    end
  end

  assign Ready   = (state_q == StResp);
  assign Err     = Ready && mis_q;
  assign Busy    = (state_q != StIdle);
  assign RData   = rdata_q;
  assign DbgData = mem_q[DbgAddr];

endmodule
